// File: rtl/sal_axi_pkg.sv
// Shared AXI types, encodings and FSM state codes for the SRAM-backed AXI responder.
package sal_axi_pkg;

    typedef logic [3:0]  axi_id_t;
    typedef logic [31:0] axi_addr_t;
    typedef logic [7:0]  axi_len_t;
    typedef logic [2:0]  axi_size_t;
    typedef logic [1:0]  axi_burst_t;
    typedef logic [1:0]  axi_resp_t;

    localparam axi_burst_t BURST_FIXED = 2'b00;
    localparam axi_burst_t BURST_INCR  = 2'b01;
    localparam axi_burst_t BURST_WRAP  = 2'b10;

    localparam axi_size_t SIZE_128 = 3'b100;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RD    = 2'd1;
    localparam logic [1:0] ST_WR    = 2'd2;
    localparam logic [1:0] ST_WRESP = 2'd3;

    // A burst is served only for full 16-byte beats with FIXED or INCR addressing.
    function automatic logic burst_legal(input axi_size_t size, input axi_burst_t burst);
        return (size == SIZE_128) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
    endfunction

endpackage

// File: rtl/sal_axi_sram_array.sv
// DEPTH x 128-bit single-port synchronous RAM with per-byte write enables.
module sal_axi_sram_array #(
    parameter int DEPTH = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [IDX_W-1:0]   addr,
    input  logic [15:0]        be,
    input  logic [127:0]       wdata,
    output logic [127:0]       rdata
);

    logic [127:0] mem [DEPTH];
    logic [127:0] rdata_q;

    // Read data is held until the next read so a stalled R beat stays stable.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 16; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sal_axi_sram_slave.sv
// AXI4 responder over an on-chip SRAM, one burst at a time with round-robin AR/AW grant.
// Define SAL_AXI_SRAM_WSTRB_EN to honour wstrb; otherwise every written beat writes all 16 bytes.
module sal_axi_sram_slave
    import sal_axi_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,

    output logic [ID_WIDTH-1:0]   rid,
    output logic [127:0]          rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,

    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,

    input  logic [127:0]          wdata,
    input  logic [15:0]           wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,

    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,

    output logic [1:0]            dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * 16);
    localparam logic [ADDR_WIDTH:0] BEAT_BYTES = (ADDR_WIDTH+1)'(16);

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;   // 1: last grant went to write
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH:0]   addr_q, addr_d;               // extra bit keeps INCR from wrapping
    axi_len_t              len_q, len_d;
    axi_burst_t            burst_q, burst_d;
    logic                  legal_q, legal_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  beat_ok_q, beat_ok_d;
    logic                  werr_q, werr_d;
    axi_resp_t             bresp_q, bresp_d;

    logic [ADDR_WIDTH:0]   ar_addr_ext, aw_addr_ext, next_addr;
    logic                  rd_ok, wr_ok;
    logic                  ram_en, ram_we;
    logic [IDX_W-1:0]      ram_addr;
    logic [15:0]           ram_be;
    logic [127:0]          ram_rdata;

    assign ar_addr_ext = {1'b0, araddr};
    assign aw_addr_ext = {1'b0, awaddr};
    assign next_addr   = (burst_q == BURST_FIXED) ? addr_q : addr_q + BEAT_BYTES;

`ifdef SAL_AXI_SRAM_WSTRB_EN
    assign ram_be = wstrb;
`else
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb;
    assign ram_be = '1;
`endif

    // Valid/ready: a transfer happens on a rising edge where both are high; a
    // raised valid and its payload are held until that edge.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        addr_d       = addr_q;
        len_d        = len_q;
        burst_d      = burst_q;
        legal_d      = legal_q;
        cnt_d        = cnt_q;
        beat_ok_d    = beat_ok_q;
        werr_d       = werr_q;
        bresp_d      = bresp_q;
        arready      = 1'b0;
        awready      = 1'b0;
        wready       = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = addr_q[4 +: IDX_W];
        rd_ok        = 1'b0;
        wr_ok        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arready = !rst && arvalid && (!awvalid || last_grant_q);
                awready = !rst && awvalid && (!arvalid || !last_grant_q);
                if (arready) begin
                    state_d      = ST_RD;
                    last_grant_d = 1'b0;
                    id_d         = arid;
                    addr_d       = ar_addr_ext;
                    len_d        = arlen;
                    burst_d      = arburst;
                    legal_d      = burst_legal(arsize, arburst);
                    cnt_d        = '0;
                    // Launch beat 0 now so its data is on rdata with the first rvalid.
                    rd_ok        = burst_legal(arsize, arburst) && (ar_addr_ext < MEM_BYTES);
                    beat_ok_d    = rd_ok;
                    ram_en       = rd_ok;
                    ram_addr     = araddr[4 +: IDX_W];
                end else if (awready) begin
                    state_d      = ST_WR;
                    last_grant_d = 1'b1;
                    id_d         = awid;
                    addr_d       = aw_addr_ext;
                    len_d        = awlen;
                    burst_d      = awburst;
                    legal_d      = burst_legal(awsize, awburst);
                    cnt_d        = '0;
                    werr_d       = !burst_legal(awsize, awburst);
                end
            end

            ST_RD: begin
                if (rready) begin
                    if (cnt_q == {1'b0, len_q}) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d     = cnt_q + 9'd1;
                        addr_d    = next_addr;
                        rd_ok     = legal_q && (next_addr < MEM_BYTES);
                        beat_ok_d = rd_ok;
                        ram_en    = rd_ok;
                        ram_addr  = next_addr[4 +: IDX_W];
                    end
                end
            end

            ST_WR: begin
                wready = 1'b1;
                if (wvalid) begin
                    wr_ok  = legal_q && (addr_q < MEM_BYTES);
                    ram_en = wr_ok && (cnt_q <= {1'b0, len_q});
                    ram_we = wr_ok && (cnt_q <= {1'b0, len_q});
                    werr_d = werr_q || !wr_ok;
                    addr_d = next_addr;
                    cnt_d  = cnt_q[8] ? cnt_q : cnt_q + 9'd1;
                    if (wlast) begin
                        state_d = ST_WRESP;
                        bresp_d = (werr_d || (cnt_q != {1'b0, len_q})) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end

            ST_WRESP: begin
                if (bready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            burst_q      <= BURST_FIXED;
            legal_q      <= 1'b0;
            cnt_q        <= '0;
            beat_ok_q    <= 1'b0;
            werr_q       <= 1'b0;
            bresp_q      <= RESP_OKAY;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            burst_q      <= burst_d;
            legal_q      <= legal_d;
            cnt_q        <= cnt_d;
            beat_ok_q    <= beat_ok_d;
            werr_q       <= werr_d;
            bresp_q      <= bresp_d;
        end
    end

    sal_axi_sram_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    assign rvalid    = (state_q == ST_RD);
    assign rlast     = rvalid && (cnt_q == {1'b0, len_q});
    assign rid       = id_q;
    assign rdata     = beat_ok_q ? ram_rdata : '0;
    assign rresp     = (rvalid && !beat_ok_q) ? RESP_SLVERR : RESP_OKAY;
    assign bvalid    = (state_q == ST_WRESP);
    assign bid       = id_q;
    assign bresp     = bresp_q;
    assign dbg_state = state_q;

endmodule
